// File: rtl/bnn_cmd_loader.sv
// Byte-stream command loader and sequencer for the BNN_MLP core.
// Opcodes: 0x01 LOAD a frame, 0x02 RUN the core, 0x03 READ the status/result byte.
module bnn_cmd_loader #(
  parameter int IN_BITS     = 4,
  parameter int W_BITS      = 16,
  parameter int B_BITS      = 16,
  parameter int RES_BITS    = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [7:0]          cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [7:0]          rsp_data,
  output logic [IN_BITS-1:0]  bnn_input,
  output logic [W_BITS-1:0]   bnn_weights,
  output logic [B_BITS-1:0]   bnn_bias,
  output logic                bnn_start,
  input  logic                bnn_done,
  input  logic [RES_BITS-1:0] bnn_result,
  output logic                busy
);

  localparam int NI    = (IN_BITS + 7) / 8;
  localparam int NW    = (W_BITS + 7) / 8;
  localparam int NB    = (B_BITS + 7) / 8;
  localparam int N     = NI + NW + NB;
  localparam int CNT_W = $clog2(N + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [IN_BITS-1:0]  in_sh_q, in_sh_d, in_q, in_d;
  logic [W_BITS-1:0]   w_sh_q, w_sh_d, w_q, w_d;
  logic [B_BITS-1:0]   b_sh_q, b_sh_d, b_q, b_d;
  logic [RES_BITS-1:0] res_q, res_d;
  logic                loaded_q, loaded_d;
  logic                res_valid_q, res_valid_d;
  logic                err_q, err_d;
  logic                cmd_fire, rsp_fire;
  logic [3:0]          res4;

  assign cmd_ready   = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign rsp_valid   = (state_q == S_RESP);
  assign bnn_start   = (state_q == S_RUN);
  assign busy        = (state_q != S_IDLE);
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign rsp_fire    = rsp_valid && rsp_ready;
  assign bnn_input   = in_q;
  assign bnn_weights = w_q;
  assign bnn_bias    = b_q;

  always_comb begin
    res4                 = '0;
    res4[RES_BITS-1:0]   = res_q;
  end

  // Flags are stable throughout RESP, so the byte holds until the handshake.
  assign rsp_data = rsp_valid ? {res_valid_q, err_q, loaded_q, 1'b0, res4} : 8'h00;

  always_comb begin
    // NOTE: every _d starts from its register value so no path through the case infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    in_sh_d     = in_sh_q;
    w_sh_d      = w_sh_q;
    b_sh_d      = b_sh_q;
    in_d        = in_q;
    w_d         = w_q;
    b_d         = b_q;
    res_d       = res_q;
    loaded_d    = loaded_q;
    res_valid_d = res_valid_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          case (cmd_data)
            8'h01: begin
              cnt_d   = '0;
              state_d = S_LOAD;
            end
            8'h02: begin
              if (loaded_q) state_d = S_RUN;
              else          err_d   = 1'b1;
            end
            8'h03:   state_d = S_RESP;
            default: err_d   = 1'b1;
          endcase
        end
      end

      S_LOAD: begin
        if (cmd_fire) begin
          // Each field starts on a byte boundary; bits past a field's width are dropped.
          for (int i = 0; i < IN_BITS; i++)
            if (int'(cnt_q) == i / 8) in_sh_d[i] = cmd_data[3'(i % 8)];
          for (int i = 0; i < W_BITS; i++)
            if (int'(cnt_q) == NI + i / 8) w_sh_d[i] = cmd_data[3'(i % 8)];
          for (int i = 0; i < B_BITS; i++)
            if (int'(cnt_q) == NI + NW + i / 8) b_sh_d[i] = cmd_data[3'(i % 8)];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N - 1)) begin
            in_d        = in_sh_d;
            w_d         = w_sh_d;
            b_d         = b_sh_d;
            loaded_d    = 1'b1;
            res_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
      end

      S_RUN: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (bnn_done) begin
          res_d       = bnn_result;
          res_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_RESP: begin
        if (rsp_fire) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      in_sh_q     <= '0;
      w_sh_q      <= '0;
      b_sh_q      <= '0;
      in_q        <= '0;
      w_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      loaded_q    <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values together.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      in_sh_q     <= in_sh_d;
      w_sh_q      <= w_sh_d;
      b_sh_q      <= b_sh_d;
      in_q        <= in_d;
      w_q         <= w_d;
      b_q         <= b_d;
      res_q       <= res_d;
      loaded_q    <= loaded_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_bnn_cmd_loader.sv
// Self-checking bench for bnn_cmd_loader: directed scenarios plus random command mix,
// with expected response bytes queued by the stimulus and compared by a separate monitor.
module tb_bnn_cmd_loader;

  localparam int IN_BITS  = 4;
  localparam int W_BITS   = 16;
  localparam int B_BITS   = 16;
  localparam int RES_BITS = 4;
  localparam int TMO      = 16;
  localparam int NI       = (IN_BITS + 7) / 8;
  localparam int NW       = (W_BITS + 7) / 8;
  localparam int NB       = (B_BITS + 7) / 8;
  localparam int N        = NI + NW + NB;

  typedef logic [7:0] frame_t [N];

  logic                clk;
  logic                rst_n;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [7:0]          cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [7:0]          rsp_data;
  logic [IN_BITS-1:0]  bnn_input;
  logic [W_BITS-1:0]   bnn_weights;
  logic [B_BITS-1:0]   bnn_bias;
  logic                bnn_start;
  logic                bnn_done;
  logic [RES_BITS-1:0] bnn_result;
  logic                busy;

  bnn_cmd_loader #(
    .IN_BITS(IN_BITS), .W_BITS(W_BITS), .B_BITS(B_BITS),
    .RES_BITS(RES_BITS), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .bnn_input(bnn_input), .bnn_weights(bnn_weights), .bnn_bias(bnn_bias),
    .bnn_start(bnn_start), .bnn_done(bnn_done), .bnn_result(bnn_result),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec  = 0;
  int         n_miss = 0;
  logic [7:0] exp_q[$];

  // Reference model: the architectural flags and committed fields only.
  bit          m_loaded, m_res_valid, m_err;
  logic [3:0]  m_result;
  logic [63:0] m_in, m_w, m_b;
  int          m_starts    = 0;
  int          starts_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_status();
    return 8'(int'(m_res_valid) * 128 + int'(m_err) * 64 + int'(m_loaded) * 32 + int'(m_result));
  endfunction

  function automatic logic [63:0] field_val(input frame_t f, input int first, input int nbytes,
                                            input int bits);
    logic [63:0] v = '0;
    for (int k = 0; k < nbytes; k++) v = v | (64'(f[first + k]) << (8 * k));
    if (bits < 64) v = v & ((64'd1 << bits) - 64'd1);
    return v;
  endfunction

  task automatic model_reset();
    m_loaded = 0; m_res_valid = 0; m_err = 0; m_result = '0;
    m_in = '0; m_w = '0; m_b = '0;
  endtask

  // Response monitor: compares on every handshake and checks the byte is held while stalled.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL rsp_unexpected: rsp_data=0x%0h with no response expected", rsp_data);
      end else if (rsp_ready) begin
        check("rsp_data", rsp_data, exp_q.pop_front());
      end else begin
        check("rsp_hold", rsp_data, exp_q[0]);
      end
    end
    if (rst_n && bnn_start) starts_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    int n  = 0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    while (!ok && n < 50) begin
      ok = cmd_ready;
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
    if (!ok) begin
      n_vec++;
      n_miss++;
      $display("FAIL cmd_accept: byte 0x%0h not accepted within 50 cycles", b);
    end
  endtask

  task automatic check_fields(input string name);
    check({name, "_input"},   64'(bnn_input),   m_in);
    check({name, "_weights"}, 64'(bnn_weights), m_w);
    check({name, "_bias"},    64'(bnn_bias),    m_b);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_input"},   64'(bnn_input),   0);
    check({name, "_weights"}, 64'(bnn_weights), 0);
    check({name, "_bias"},    64'(bnn_bias),    0);
    check({name, "_start"},   bnn_start,        0);
    check({name, "_rsp_valid"}, rsp_valid,      0);
    check({name, "_rsp_data"},  rsp_data,       0);
    check({name, "_busy"},    busy,             0);
  endtask

  // Asserts rst_n between clock edges and checks outputs clear with no edge in between.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    model_reset();
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_load(input frame_t f, input int abort_after);
    send_byte(8'h01);
    for (int i = 0; i < N; i++) begin
      send_byte(f[i]);
      if (abort_after == i + 1) begin
        async_reset();
        return;
      end
      if (i == N - 1) begin
        m_in = field_val(f, 0, NI, IN_BITS);
        m_w  = field_val(f, NI, NW, W_BITS);
        m_b  = field_val(f, NI + NW, NB, B_BITS);
        m_loaded    = 1;
        m_res_valid = 0;
        check_fields("load_commit");
      end else begin
        check_fields("load_partial");
      end
    end
    check("load_idle", busy, 0);
  endtask

  // delay>0: bnn_done is high during WAIT cycle 'delay'; delay<=0: never done (timeout).
  task automatic do_run(input int delay, input logic [3:0] r, input bit poke);
    send_byte(8'h02);
    if (!m_loaded) begin
      m_err = 1;
      check("run_noload_start", bnn_start, 0);
      check("run_noload_busy", busy, 0);
      return;
    end
    m_starts++;
    check("run_start", bnn_start, 1);
    tick();
    check("start_width", bnn_start, 0);
    if (delay > 0) begin
      repeat (delay - 1) tick();
      bnn_done   = 1'b1;
      bnn_result = r;
      tick();
      bnn_done   = 1'b0;
      bnn_result = 4'($urandom);
      m_result    = r;
      m_res_valid = 1;
      check("done_to_idle", busy, 0);
    end else begin
      cmd_valid = poke;
      cmd_data  = 8'h01;
      for (int c = 1; c < TMO; c++) begin
        if (poke) check("wait_cmd_ready", cmd_ready, 0);
        tick();
      end
      check("wait_last_busy", busy, 1);
      tick();
      cmd_valid = 1'b0;
      m_err = 1;
      check("timeout_to_idle", busy, 0);
    end
  endtask

  task automatic do_read(input int hold);
    if (hold == 0) rsp_ready = 1'b1;
    send_byte(8'h03);
    exp_q.push_back(model_status());
    m_err = 0;
    check("read_latency", rsp_valid, 1);
    check("read_cmd_ready", cmd_ready, 0);
    if (hold > 0) begin
      repeat (hold) tick();
      rsp_ready = 1'b1;
    end
    tick();
    rsp_ready = 1'b0;
    check("resp_done", rsp_valid, 0);
  endtask

  task automatic do_bad_op(input logic [7:0] op);
    send_byte(op);
    m_err = 1;
    check("bad_op_idle", busy, 0);
  endtask

  task automatic stray_done();
    bnn_done   = 1'b1;
    bnn_result = 4'($urandom);
    tick();
    tick();
    bnn_done = 1'b0;
    check("stray_done_idle", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    frame_t f0, fr;
    logic [7:0] op;
    f0 = '{8'hA5, 8'h34, 8'h12, 8'h78, 8'h56};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00;
    rsp_ready = 1'b0; bnn_done = 1'b0; bnn_result = '0;
    model_reset();
    #12;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Reference frame; fields must stay at zero until the final byte.
    do_load(f0, 0);
    check("ref_input",   64'(bnn_input),   64'h5);
    check("ref_weights", 64'(bnn_weights), 64'h1234);
    check("ref_bias",    64'(bnn_bias),    64'h5678);

    do_run(3, 4'hA, 1'b0);
    do_read(5);
    check("start_count_one", starts_seen, 1);

    // RUN without a loaded frame, then read-to-clear of err.
    async_reset();
    do_run(1, 4'h0, 1'b0);
    do_read(0);
    do_read(0);

    // Timeout with bytes offered during WAIT.
    fr = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    do_load(fr, 0);
    do_run(0, 4'h0, 1'b1);
    do_read(2);

    do_bad_op(8'h7F);
    do_read(1);

    // Done in the final WAIT cycle beats the timeout.
    do_run(TMO, 4'h3, 1'b0);
    do_read(0);

    stray_done();
    do_read(0);

    // Reset in the middle of a load, then a clean reload from byte 0.
    do_load(fr, 3);
    do_load(f0, 0);
    do_read(0);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          for (int k = 0; k < N; k++) fr[k] = 8'($urandom);
          do_load(fr, 0);
        end
        2: do_run(int'($urandom_range(0, TMO)), 4'($urandom), 1'($urandom));
        3: do_read(int'($urandom_range(0, 3)));
        4: begin
          op = 8'($urandom);
          while (op == 8'h01 || op == 8'h02 || op == 8'h03) op = 8'($urandom);
          do_bad_op(op);
        end
        default: stray_done();
      endcase
    end
    do_read(0);

    tick();
    check("start_count", starts_seen, m_starts);
    check("rsp_queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
